// File: rtl/loa_pkg.sv
// -----------------------------------------------------------------------------
// loa_pkg
// Shared definitions for the approximate-adder vector generator:
//   - state_e     : run-control FSM states (IDLE, RUN, DONE)
//   - lfsr_taps() : Galois tap mask for 8/16/32-bit LFSRs (right-shift form)
//   - lfsr_step() : one Galois LFSR step for a given width
//   - vec_width() : packed vector width {A, B, Cout, Sum} = 3N+1
// -----------------------------------------------------------------------------
package loa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Tap masks for a right-shifting Galois LFSR: term x^e maps to bit e-1.
  //   w=8  : x^8+x^6+x^5+x^4+1
  //   w=16 : x^16+x^15+x^13+x^4+1
  //   w=32 : x^32+x^22+x^2+x+1
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_D008;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // One LFSR step; s must be zero above bit w-1 (the result then is too).
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input int w);
    logic [31:0] nxt;
    nxt = s >> 1;
    if (s[0]) begin
      nxt = nxt ^ lfsr_taps(w);
    end
    return nxt;
  endfunction

  function automatic int vec_width(input int n);
    return 3 * n + 1;
  endfunction

endpackage

// File: rtl/loa_vector_gen_lfsr.sv
// -----------------------------------------------------------------------------
// lfsr_galois
// W-bit Galois LFSR holding the pseudo-random operand sequence.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (state resets to 1)
//   load     : load seed (has priority over step)
//   seed     : value loaded on load
//   step     : advance one step
//   state    : current LFSR state
// -----------------------------------------------------------------------------
module lfsr_galois
  import loa_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic [W-1:0] state
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (step) begin
      state_d = W'(lfsr_step(32'(state_q), W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= W'(1);
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/loa_vector_gen.sv
// -----------------------------------------------------------------------------
// loa_vector_gen
// Streams (A, B) operand pairs with their exact reference {Cout, Sum} over a
// valid/ready handshake, either exhaustively (A-major) or from a Galois LFSR.
// Ports:
//   i_Clk, i_Rst       : clock, asynchronous active-high reset
//   i_Start            : begin a run (honoured in IDLE/DONE only)
//   i_Mode             : 0 = exhaustive, 1 = pseudo-random
//   i_Seed, i_Count    : LFSR seed and random vector count, sampled with start
//   i_Ready            : consumer accepts current vector
//   o_Valid            : vector outputs valid
//   o_A, o_B           : operands
//   o_Cout, o_Sum      : exact A+B (carry-in 0)
//   o_Vector           : {o_A, o_B, o_Cout, o_Sum}
//   o_Last             : current vector is the final one of the run
//   o_Busy             : run in progress
//   o_Done             : sticky end-of-run flag
// -----------------------------------------------------------------------------
module loa_vector_gen
  import loa_pkg::*;
#(
  parameter int N  = 4,
  parameter int VW = vec_width(N)
) (
  input  logic           i_Clk,
  input  logic           i_Rst,
  input  logic           i_Start,
  input  logic           i_Mode,
  input  logic [2*N-1:0] i_Seed,
  input  logic [2*N-1:0] i_Count,
  input  logic           i_Ready,
  output logic           o_Valid,
  output logic [N-1:0]   o_A,
  output logic [N-1:0]   o_B,
  output logic           o_Cout,
  output logic [N-1:0]   o_Sum,
  output logic [VW-1:0]  o_Vector,
  output logic           o_Last,
  output logic           o_Busy,
  output logic           o_Done
);

  localparam int LW = 2 * N;
  localparam logic [LW-1:0] LAST_IDX = '1;

  state_e        state_q, state_d;
  logic          xfer;
  logic          empty_run, load_first, advance, finish;

  logic          mode_q, mode_d;
  logic [LW-1:0] ab_q, ab_d;      // current {A,B}; doubles as exhaustive index
  logic [LW-1:0] rem_q, rem_d;    // remaining random vectors incl. current
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          cout_q, cout_d;
  logic [N-1:0]  sum_q, sum_d;

  logic [LW-1:0] seed_eff;
  logic [LW-1:0] lfsr_preload;
  logic [LW-1:0] lfsr_state;
  logic          lfsr_step_en;

  assign xfer = valid_q && i_Ready;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_eff = (i_Seed == '0) ? LW'(1) : i_Seed;

  // The LFSR runs one step ahead of the presented vector so the successor
  // is already available on the transfer edge.
  assign lfsr_preload = LW'(lfsr_step(32'(seed_eff), LW));
  assign lfsr_step_en = advance && mode_q;

  lfsr_galois #(
    .W(LW)
  ) u_lfsr (
    .clk  (i_Clk),
    .rst  (i_Rst),
    .load (load_first),
    .seed (lfsr_preload),
    .step (lfsr_step_en),
    .state(lfsr_state)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (i_Start) begin
          state_d = (i_Mode && (i_Count == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (xfer && last_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: control outputs ----------------
  always_comb begin
    empty_run  = 1'b0;
    load_first = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        empty_run  = i_Start && i_Mode && (i_Count == '0);
        load_first = i_Start && !(i_Mode && (i_Count == '0));
      end
      RUN: begin
        advance = xfer && !last_q;
        finish  = xfer && last_q;
      end
      default: ;
    endcase
  end

  assign o_Busy = (state_q == RUN);

  // ---------------- Datapath next values ----------------
  always_comb begin
    mode_d  = mode_q;
    ab_d    = ab_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = done_q;
    if (load_first) begin
      mode_d  = i_Mode;
      ab_d    = i_Mode ? seed_eff : '0;
      rem_d   = i_Count;
      last_d  = i_Mode && (i_Count == LW'(1));
      valid_d = 1'b1;
      done_d  = 1'b0;
    end else if (empty_run || finish) begin
      rem_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b1;
    end else if (advance) begin
      rem_d = rem_q - LW'(1);
      if (mode_q) begin
        ab_d   = lfsr_state;
        last_d = (rem_q == LW'(2));
      end else begin
        ab_d   = ab_q + LW'(1);
        last_d = (ab_q == (LAST_IDX - LW'(1)));
      end
    end
    // Reference result at N+1 bits so the carry is never lost.
    {cout_d, sum_d} = {1'b0, ab_d[LW-1:N]} + {1'b0, ab_d[N-1:0]};
  end

  // ---------------- Output register stage ----------------
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      mode_q  <= 1'b0;
      ab_q    <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      ab_q    <= ab_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      sum_q   <= sum_d;
    end
  end

  assign o_Valid  = valid_q;
  assign o_A      = ab_q[LW-1:N];
  assign o_B      = ab_q[N-1:0];
  assign o_Cout   = cout_q;
  assign o_Sum    = sum_q;
  assign o_Vector = {ab_q, cout_q, sum_q};
  assign o_Last   = last_q;
  assign o_Done   = done_q;

endmodule
